// File: rtl/vending_machine_mc.sv
// Multi-channel vending controller: coin credit, discounted vend, change, per-channel stock.
// All outputs registered; a successful select vends on the next cycle and returns change the cycle after.
module vending_machine_mc #(
  parameter int NUM_PROD   = 4,
  parameter int CW         = 16,
  parameter int SW         = 4,
  parameter int STOCK_INIT = 2,
  localparam int IW        = ($clog2(NUM_PROD) > 1) ? $clog2(NUM_PROD) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   coin_valid,
  input  logic [CW-1:0]          coin_value,
  input  logic                   sel_valid,
  input  logic [IW-1:0]          sel_idx,
  input  logic                   cancel,
  input  logic [NUM_PROD*CW-1:0] price_flat,
  input  logic                   disc_en,
  input  logic                   disc_sel,
  input  logic [CW-1:0]          disc_a,
  input  logic [CW-1:0]          disc_b,
  input  logic                   refill_valid,
  input  logic [IW-1:0]          refill_idx,
  input  logic [SW-1:0]          refill_cnt,
  output logic [CW-1:0]          credit,
  output logic                   dispense_valid,
  output logic [IW-1:0]          dispense_idx,
  output logic                   change_valid,
  output logic [CW-1:0]          change_amt,
  output logic                   err_valid,
  output logic [1:0]             err_code,
  output logic [NUM_PROD*SW-1:0] stock_flat,
  output logic [1:0]             state_out
);

  typedef enum logic [1:0] {IDLE = 2'd0, CREDIT = 2'd1, VEND = 2'd2, CHANGE = 2'd3} state_t;

  localparam logic [IW:0] NP = NUM_PROD[IW:0];

  state_t          state;
  logic [IW-1:0]   vend_idx;
  logic [CW-1:0]   vend_price;
  logic [SW-1:0]   stock     [NUM_PROD];
  logic [SW-1:0]   stock_nxt [NUM_PROD];
  logic [CW-1:0]   price     [NUM_PROD];
  logic [SW:0]     refill_sum;
  logic            sel_in_range;
  logic [IW-1:0]   sel_safe;
  logic [CW-1:0]   disc_amt;
  logic [CW:0]     eff_wide;
  logic [CW-1:0]   eff_price;
  logic [CW:0]     coin_sum;

  always_comb begin
    for (int i = 0; i < NUM_PROD; i++) price[i] = price_flat[i*CW +: CW];
  end

  // Out-of-range selects are reported as errors; the safe index only keeps array reads in bounds.
  assign sel_in_range = ({1'b0, sel_idx} < NP);
  assign sel_safe     = sel_in_range ? sel_idx : '0;
  assign disc_amt     = disc_en ? (disc_sel ? disc_a : disc_b) : '0;
  assign eff_wide     = {1'b0, price[sel_safe]} - {1'b0, disc_amt};
  assign eff_price    = eff_wide[CW] ? '0 : eff_wide[CW-1:0];
  assign coin_sum     = {1'b0, credit} + {1'b0, coin_value};

  // Refill saturates first, then a vend on the same channel takes one away.
  always_comb begin
    refill_sum = '0;
    for (int i = 0; i < NUM_PROD; i++) begin
      refill_sum = {1'b0, stock[i]};
      if (refill_valid && refill_idx == IW'(i)) refill_sum = refill_sum + {1'b0, refill_cnt};
      stock_nxt[i] = refill_sum[SW] ? '1 : refill_sum[SW-1:0];
      if (state == VEND && vend_idx == IW'(i)) stock_nxt[i] = stock_nxt[i] - SW'(1);
    end
  end

  always_comb begin
    stock_flat = '0;
    for (int i = 0; i < NUM_PROD; i++) stock_flat[i*SW +: SW] = stock[i];
  end

  assign state_out = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      credit         <= '0;
      vend_idx       <= '0;
      vend_price     <= '0;
      dispense_valid <= 1'b0;
      dispense_idx   <= '0;
      change_valid   <= 1'b0;
      change_amt     <= '0;
      err_valid      <= 1'b0;
      err_code       <= 2'b00;
      for (int i = 0; i < NUM_PROD; i++) stock[i] <= SW'(STOCK_INIT);
    end else begin
      dispense_valid <= 1'b0;
      change_valid   <= 1'b0;
      err_valid      <= 1'b0;
      for (int i = 0; i < NUM_PROD; i++) stock[i] <= stock_nxt[i];
      case (state)
        IDLE, CREDIT: begin
          if (cancel && state == CREDIT) begin
            state <= CHANGE;
            if (coin_valid) begin
              err_valid <= 1'b1;
              err_code  <= 2'b11;
            end
          end else if (sel_valid) begin
            if (!sel_in_range || stock[sel_safe] == '0) begin
              err_valid <= 1'b1;
              err_code  <= 2'b10;
            end else if (credit < eff_price) begin
              err_valid <= 1'b1;
              err_code  <= 2'b01;
            end else begin
              vend_idx   <= sel_safe;
              vend_price <= eff_price;
              state      <= VEND;
              if (coin_valid) begin
                err_valid <= 1'b1;
                err_code  <= 2'b11;
              end
            end
          end else if (coin_valid) begin
            if (coin_sum[CW]) begin
              err_valid <= 1'b1;
              err_code  <= 2'b11;
            end else begin
              credit <= coin_sum[CW-1:0];
              if (coin_sum[CW-1:0] != '0) state <= CREDIT;
            end
          end
        end
        VEND: begin
          dispense_valid <= 1'b1;
          dispense_idx   <= vend_idx;
          credit         <= credit - vend_price;
          state          <= CHANGE;
          if (coin_valid) begin
            err_valid <= 1'b1;
            err_code  <= 2'b11;
          end
        end
        CHANGE: begin
          if (credit != '0) begin
            change_valid <= 1'b1;
            change_amt   <= credit;
          end
          credit <= '0;
          state  <= IDLE;
          if (coin_valid) begin
            err_valid <= 1'b1;
            err_code  <= 2'b11;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vending_machine_mc.sv
// Bench for vending_machine_mc: directed vector table, corner sequences, and random traffic vs a transaction model.
module tb_vending_machine_mc;

  localparam bit H = 1'b1;
  localparam bit L = 1'b0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        coin_valid = 1'b0;
  logic [15:0] coin_value = '0;
  logic        sel_valid = 1'b0;
  logic [1:0]  sel_idx = '0;
  logic        cancel = 1'b0;
  logic [63:0] price_flat = {16'd80, 16'd0, 16'd150, 16'd50};
  logic        disc_en = 1'b0;
  logic        disc_sel = 1'b0;
  logic [15:0] disc_a = '0;
  logic [15:0] disc_b = '0;
  logic        refill_valid = 1'b0;
  logic [1:0]  refill_idx = '0;
  logic [3:0]  refill_cnt = '0;

  logic [15:0] credit;
  logic        dispense_valid;
  logic [1:0]  dispense_idx;
  logic        change_valid;
  logic [15:0] change_amt;
  logic        err_valid;
  logic [1:0]  err_code;
  logic [15:0] stock_flat;
  logic [1:0]  state_out;

  logic [15:0] credit3;
  logic        dispense_valid3;
  logic [1:0]  dispense_idx3;
  logic        change_valid3;
  logic [15:0] change_amt3;
  logic        err_valid3;
  logic [1:0]  err_code3;
  logic [11:0] stock_flat3;
  logic [1:0]  state_out3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vending_machine_mc dut (
    .clk(clk), .reset(reset), .coin_valid(coin_valid), .coin_value(coin_value),
    .sel_valid(sel_valid), .sel_idx(sel_idx), .cancel(cancel), .price_flat(price_flat),
    .disc_en(disc_en), .disc_sel(disc_sel), .disc_a(disc_a), .disc_b(disc_b),
    .refill_valid(refill_valid), .refill_idx(refill_idx), .refill_cnt(refill_cnt),
    .credit(credit), .dispense_valid(dispense_valid), .dispense_idx(dispense_idx),
    .change_valid(change_valid), .change_amt(change_amt), .err_valid(err_valid),
    .err_code(err_code), .stock_flat(stock_flat), .state_out(state_out)
  );

  vending_machine_mc #(.NUM_PROD(3)) dut3 (
    .clk(clk), .reset(reset), .coin_valid(coin_valid), .coin_value(coin_value),
    .sel_valid(sel_valid), .sel_idx(sel_idx), .cancel(cancel), .price_flat(price_flat[47:0]),
    .disc_en(disc_en), .disc_sel(disc_sel), .disc_a(disc_a), .disc_b(disc_b),
    .refill_valid(refill_valid), .refill_idx(refill_idx), .refill_cnt(refill_cnt),
    .credit(credit3), .dispense_valid(dispense_valid3), .dispense_idx(dispense_idx3),
    .change_valid(change_valid3), .change_amt(change_amt3), .err_valid(err_valid3),
    .err_code(err_code3), .stock_flat(stock_flat3), .state_out(state_out3)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    reset = 1'b0; coin_valid = 1'b0; coin_value = '0; sel_valid = 1'b0; sel_idx = '0;
    cancel = 1'b0; disc_en = 1'b0; disc_sel = 1'b0; disc_a = '0; disc_b = '0;
    refill_valid = 1'b0; refill_idx = '0; refill_cnt = '0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit rst; bit cv; logic [15:0] cval; bit sv; logic [1:0] sidx; bit can;
    bit den; bit dsel; logic [15:0] da;
    int st; int cr; bit dv; int di; bit chv; int ca; bit ev; int ec; logic [15:0] stk;
  } vec_t;

  vec_t tbl [24];

  // ---------------- transaction-level reference model ----------------
  int m_credit, m_vidx, m_vprice, m_didx, m_camt, m_ecode;
  int m_stock [4];
  bit m_vend, m_chg, m_dv, m_chv, m_ev;

  task automatic m_err(input int code);
    m_ev = 1'b1;
    m_ecode = code;
  endtask

  task automatic model_step();
    int disc, eff, sum;
    bit vended;
    m_dv = 1'b0; m_chv = 1'b0; m_ev = 1'b0; vended = 1'b0;
    if (reset) begin
      m_credit = 0; m_vend = 1'b0; m_chg = 1'b0; m_didx = 0; m_camt = 0; m_ecode = 0;
      for (int i = 0; i < 4; i++) m_stock[i] = 2;
      return;
    end
    if (m_vend) begin
      m_dv = 1'b1; m_didx = m_vidx; m_credit -= m_vprice;
      m_vend = 1'b0; m_chg = 1'b1; vended = 1'b1;
      if (coin_valid) m_err(3);
    end else if (m_chg) begin
      if (m_credit != 0) begin m_chv = 1'b1; m_camt = m_credit; end
      m_credit = 0; m_chg = 1'b0;
      if (coin_valid) m_err(3);
    end else begin
      disc = disc_en ? (disc_sel ? int'(disc_a) : int'(disc_b)) : 0;
      eff = int'(price_flat[int'(sel_idx)*16 +: 16]) - disc;
      if (eff < 0) eff = 0;
      if (cancel && m_credit != 0) begin
        m_chg = 1'b1;
        if (coin_valid) m_err(3);
      end else if (sel_valid) begin
        if (m_stock[sel_idx] == 0) m_err(2);
        else if (m_credit < eff) m_err(1);
        else begin
          m_vend = 1'b1; m_vidx = int'(sel_idx); m_vprice = eff;
          if (coin_valid) m_err(3);
        end
      end else if (coin_valid) begin
        if (m_credit + int'(coin_value) <= 65535) m_credit += int'(coin_value);
        else m_err(3);
      end
    end
    if (refill_valid) begin
      sum = m_stock[refill_idx] + int'(refill_cnt);
      m_stock[refill_idx] = (sum > 15) ? 15 : sum;
    end
    if (vended) m_stock[m_didx] -= 1;
  endtask

  function automatic int m_state();
    return m_vend ? 2 : m_chg ? 3 : (m_credit != 0) ? 1 : 0;
  endfunction

  task automatic check_model(input int cyc);
    chk($sformatf("r%0d_state", cyc), int'(state_out), m_state());
    chk($sformatf("r%0d_credit", cyc), int'(credit), m_credit);
    chk($sformatf("r%0d_disp_vld", cyc), int'(dispense_valid), int'(m_dv));
    chk($sformatf("r%0d_disp_idx", cyc), int'(dispense_idx), m_didx);
    chk($sformatf("r%0d_chg_vld", cyc), int'(change_valid), int'(m_chv));
    chk($sformatf("r%0d_chg_amt", cyc), int'(change_amt), m_camt);
    chk($sformatf("r%0d_err_vld", cyc), int'(err_valid), int'(m_ev));
    if (m_ev) chk($sformatf("r%0d_err_code", cyc), int'(err_code), m_ecode);
    for (int i = 0; i < 4; i++)
      chk($sformatf("r%0d_stock%0d", cyc, i), int'(stock_flat[i*4 +: 4]), m_stock[i]);
  endtask

  task automatic rand_inputs();
    bit idle;
    idle = (m_credit == 0) && !m_vend && !m_chg;
    reset        = ($urandom_range(0, 79) == 0);
    coin_valid   = ($urandom_range(0, 2) == 0);
    coin_value   = ($urandom_range(0, 19) == 0) ? 16'($urandom_range(60000, 65535))
                                                : 16'($urandom_range(1, 200));
    sel_valid    = ($urandom_range(0, 3) == 0);
    sel_idx      = 2'($urandom_range(0, 3));
    cancel       = ($urandom_range(0, 11) == 0) && !idle;
    disc_en      = ($urandom_range(0, 1) == 1);
    disc_sel     = ($urandom_range(0, 1) == 1);
    disc_a       = 16'($urandom_range(0, 100));
    disc_b       = 16'($urandom_range(0, 100));
    refill_valid = ($urandom_range(0, 7) == 0);
    refill_idx   = 2'($urandom_range(0, 3));
    refill_cnt   = 4'($urandom_range(0, 15));
    for (int i = 0; i < 4; i++) price_flat[i*16 +: 16] = 16'($urandom_range(0, 250));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "bench timeout");
  end

  initial begin
    // prices: ch0=50 ch1=150 ch2=0 ch3=80
    tbl[0]  = '{H,L,16'd0,    L,2'd0,L,L,L,16'd0,  0,0,    L,0,L,0,    L,0,16'h2222};
    tbl[1]  = '{L,H,16'd0,    L,2'd0,L,L,L,16'd0,  0,0,    L,0,L,0,    L,0,16'h2222};
    tbl[2]  = '{L,H,16'd100,  L,2'd0,L,L,L,16'd0,  1,100,  L,0,L,0,    L,0,16'h2222};
    tbl[3]  = '{L,H,16'd100,  L,2'd0,L,L,L,16'd0,  1,200,  L,0,L,0,    L,0,16'h2222};
    tbl[4]  = '{L,L,16'd0,    H,2'd1,L,L,L,16'd0,  2,200,  L,0,L,0,    L,0,16'h2222};
    tbl[5]  = '{L,L,16'd0,    L,2'd0,L,L,L,16'd0,  3,50,   H,1,L,0,    L,0,16'h2212};
    tbl[6]  = '{L,L,16'd0,    L,2'd0,L,L,L,16'd0,  0,0,    L,1,H,50,   L,0,16'h2212};
    tbl[7]  = '{L,L,16'd0,    L,2'd0,L,L,L,16'd0,  0,0,    L,1,L,50,   L,0,16'h2212};
    tbl[8]  = '{L,H,16'd100,  L,2'd0,L,L,L,16'd0,  1,100,  L,1,L,50,   L,0,16'h2212};
    tbl[9]  = '{L,L,16'd0,    H,2'd1,L,H,H,16'd30, 1,100,  L,1,L,50,   H,1,16'h2212};
    tbl[10] = '{L,L,16'd0,    L,2'd0,H,L,L,16'd0,  3,100,  L,1,L,50,   L,0,16'h2212};
    tbl[11] = '{L,L,16'd0,    L,2'd0,L,L,L,16'd0,  0,0,    L,1,H,100,  L,0,16'h2212};
    tbl[12] = '{L,L,16'd0,    H,2'd2,L,L,L,16'd0,  2,0,    L,1,L,100,  L,0,16'h2212};
    tbl[13] = '{L,L,16'd0,    L,2'd0,L,L,L,16'd0,  3,0,    H,2,L,100,  L,0,16'h2112};
    tbl[14] = '{L,L,16'd0,    L,2'd0,L,L,L,16'd0,  0,0,    L,2,L,100,  L,0,16'h2112};
    tbl[15] = '{L,L,16'd0,    H,2'd2,L,L,L,16'd0,  2,0,    L,2,L,100,  L,0,16'h2112};
    tbl[16] = '{L,L,16'd0,    L,2'd0,L,L,L,16'd0,  3,0,    H,2,L,100,  L,0,16'h2012};
    tbl[17] = '{L,L,16'd0,    L,2'd0,L,L,L,16'd0,  0,0,    L,2,L,100,  L,0,16'h2012};
    tbl[18] = '{L,L,16'd0,    H,2'd2,L,L,L,16'd0,  0,0,    L,2,L,100,  H,2,16'h2012};
    tbl[19] = '{L,H,16'd65500,L,2'd0,L,L,L,16'd0,  1,65500,L,2,L,100,  L,0,16'h2012};
    tbl[20] = '{L,H,16'd100,  L,2'd0,L,L,L,16'd0,  1,65500,L,2,L,100,  H,3,16'h2012};
    tbl[21] = '{L,L,16'd0,    H,2'd0,L,L,L,16'd0,  2,65500,L,2,L,100,  L,0,16'h2012};
    tbl[22] = '{L,H,16'd10,   L,2'd0,L,L,L,16'd0,  3,65450,H,0,L,100,  H,3,16'h2011};
    tbl[23] = '{L,L,16'd0,    L,2'd0,L,L,L,16'd0,  0,0,    L,0,H,65450,L,0,16'h2011};

    for (int k = 0; k < 24; k++) begin
      clear_inputs();
      reset = tbl[k].rst; coin_valid = tbl[k].cv; coin_value = tbl[k].cval;
      sel_valid = tbl[k].sv; sel_idx = tbl[k].sidx; cancel = tbl[k].can;
      disc_en = tbl[k].den; disc_sel = tbl[k].dsel; disc_a = tbl[k].da;
      tick();
      chk($sformatf("t%0d_state", k), int'(state_out), tbl[k].st);
      chk($sformatf("t%0d_credit", k), int'(credit), tbl[k].cr);
      chk($sformatf("t%0d_disp_vld", k), int'(dispense_valid), int'(tbl[k].dv));
      chk($sformatf("t%0d_disp_idx", k), int'(dispense_idx), tbl[k].di);
      chk($sformatf("t%0d_chg_vld", k), int'(change_valid), int'(tbl[k].chv));
      chk($sformatf("t%0d_chg_amt", k), int'(change_amt), tbl[k].ca);
      chk($sformatf("t%0d_err_vld", k), int'(err_valid), int'(tbl[k].ev));
      if (tbl[k].ev || tbl[k].rst) chk($sformatf("t%0d_err_code", k), int'(err_code), tbl[k].ec);
      chk($sformatf("t%0d_stock", k), int'(stock_flat), int'(tbl[k].stk));
    end

    // reset during the vend cycle discards credit without a change pulse
    clear_inputs(); coin_valid = 1'b1; coin_value = 16'd100; tick();
    clear_inputs(); sel_valid = 1'b1; sel_idx = 2'd0; tick();
    chk("rstvend_pre_state", int'(state_out), 2);
    clear_inputs(); reset = 1'b1; tick();
    chk("rstvend_state", int'(state_out), 0);
    chk("rstvend_credit", int'(credit), 0);
    chk("rstvend_disp", int'(dispense_valid), 0);
    chk("rstvend_chg", int'(change_valid), 0);
    chk("rstvend_stock", int'(stock_flat), 16'h2222);
    clear_inputs(); tick();
    chk("rstvend_nochg", int'(change_valid), 0);
    chk("rstvend_idle", int'(state_out), 0);

    // refill saturation and refill coinciding with a vend on the same channel
    clear_inputs(); refill_valid = 1'b1; refill_idx = 2'd0; refill_cnt = 4'd15; tick();
    chk("refill_sat15", int'(stock_flat), 16'h222F);
    clear_inputs(); refill_valid = 1'b1; refill_idx = 2'd0; refill_cnt = 4'd3; tick();
    chk("refill_sat_hold", int'(stock_flat), 16'h222F);
    clear_inputs(); coin_valid = 1'b1; coin_value = 16'd100; tick();
    clear_inputs(); sel_valid = 1'b1; sel_idx = 2'd3; tick();
    clear_inputs(); refill_valid = 1'b1; refill_idx = 2'd3; refill_cnt = 4'd1; tick();
    chk("refvend_disp", int'(dispense_valid), 1);
    chk("refvend_idx", int'(dispense_idx), 3);
    chk("refvend_stock", int'(stock_flat), 16'h222F);
    chk("refvend_credit", int'(credit), 20);
    clear_inputs(); tick();
    chk("refvend_chg_vld", int'(change_valid), 1);
    chk("refvend_chg_amt", int'(change_amt), 20);

    // out-of-range channel on a three-channel build
    clear_inputs(); reset = 1'b1; tick();
    clear_inputs(); sel_valid = 1'b1; sel_idx = 2'd3; tick();
    chk("np3_err_vld", int'(err_valid3), 1);
    chk("np3_err_code", int'(err_code3), 2);
    chk("np3_state", int'(state_out3), 0);
    clear_inputs(); refill_valid = 1'b1; refill_idx = 2'd3; refill_cnt = 4'd5; tick();
    chk("np3_refill_ignored", int'(stock_flat3), 12'h222);

    // random traffic against the model
    clear_inputs(); reset = 1'b1;
    model_step(); tick(); check_model(0);
    for (int c = 1; c <= 1500; c++) begin
      rand_inputs();
      model_step();
      tick();
      check_model(c);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
